// File: rtl/simmem_release_scheduler.sv
// Per-slot delay scheduler for the simulated memory message bank.
// A slot becomes releasable once its countdown reaches zero.
module simmem_release_scheduler #(
    parameter int NumSlots   = 128,
    parameter int DelayWidth = 8,
    localparam int AddrWidth = $clog2(NumSlots),
    localparam int CntWidth  = $clog2(NumSlots) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sched_valid_i,
    output logic                  sched_ready_o,
    input  logic [AddrWidth-1:0]  sched_addr_i,
    input  logic [DelayWidth-1:0] sched_delay_i,
    input  logic                  freeze_i,
    output logic [NumSlots-1:0]   release_en_o,
    input  logic                  released_valid_i,
    input  logic [AddrWidth-1:0]  released_addr_i,
    output logic [CntWidth-1:0]   pending_cnt_o,
    output logic                  err_o
);

    logic [NumSlots-1:0]   busy;
    logic [DelayWidth-1:0] cnt [NumSlots];
    logic                  sched_hs;
    logic                  rel_ok;

    always_comb begin
        release_en_o = '0;
        for (int k = 0; k < NumSlots; k++) begin
            release_en_o[k] = busy[k] && (cnt[k] == '0);
        end
    end

    assign sched_ready_o = !busy[sched_addr_i];
    assign sched_hs      = sched_valid_i && sched_ready_o;
    // Only a slot already signalling release may be retired.
    assign rel_ok        = released_valid_i && release_en_o[released_addr_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy <= '0;
        end else begin
            if (sched_hs) begin
                busy[sched_addr_i] <= 1'b1;
            end
            if (rel_ok) begin
                busy[released_addr_i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumSlots; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NumSlots; k++) begin
                if (sched_hs && (sched_addr_i == AddrWidth'(k))) begin
                    cnt[k] <= sched_delay_i;
                end else if (!freeze_i && busy[k] && (cnt[k] != '0)) begin
                    cnt[k] <= cnt[k] - DelayWidth'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_cnt_o <= '0;
        end else if (sched_hs && !rel_ok) begin
            pending_cnt_o <= pending_cnt_o + CntWidth'(1);
        end else if (rel_ok && !sched_hs) begin
            pending_cnt_o <= pending_cnt_o - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (released_valid_i && !rel_ok) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Directed bench for simmem_release_scheduler with a slot-level
// reference model compared on every falling clock edge.
module tb_simmem_release_scheduler;

    localparam int N  = 128;
    localparam int DW = 8;
    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;

    logic          clk;
    logic          rst_n;
    logic          sv;
    logic          srdy;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic          fz;
    logic [N-1:0]  ren;
    logic          rv;
    logic [AW-1:0] ra;
    logic [CW-1:0] pend;
    logic          err;

    int checks = 0;
    int errors = 0;

    simmem_release_scheduler #(
        .NumSlots  (N),
        .DelayWidth(DW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .sched_valid_i   (sv),
        .sched_ready_o   (srdy),
        .sched_addr_i    (sa),
        .sched_delay_i   (sd),
        .freeze_i        (fz),
        .release_en_o    (ren),
        .released_valid_i(rv),
        .released_addr_i (ra),
        .pending_cnt_o   (pend),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each slot is either free, or occupied with a number of
    // unfrozen cycles still to wait before it may be released.
    bit m_busy [N];
    int m_rem  [N];
    bit m_err;

    wire m_hs = sv && !m_busy[sa];
    wire m_ok = rv && m_busy[ra] && (m_rem[ra] == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_busy[k] <= 1'b0;
                m_rem[k]  <= 0;
            end
            m_err <= 1'b0;
        end else begin
            if (!fz) begin
                for (int k = 0; k < N; k++) begin
                    if (m_busy[k] && m_rem[k] > 0) m_rem[k] <= m_rem[k] - 1;
                end
            end
            if (m_hs) begin
                m_busy[sa] <= 1'b1;
                m_rem[sa]  <= int'(sd);
            end
            if (m_ok) m_busy[ra] <= 1'b0;
            if (rv && !m_ok) m_err <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [N-1:0] e_ren;
        int           e_pend;
        e_pend = 0;
        for (int k = 0; k < N; k++) begin
            e_ren[k] = m_busy[k] && (m_rem[k] == 0);
            if (m_busy[k]) e_pend++;
        end
        chk("model_ren", ren, e_ren);
        chk("model_pend", N'(pend), N'(e_pend));
        chk("model_err", N'(err), N'(m_err));
        chk("model_ready", N'(srdy), N'(!m_busy[sa]));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input int a, input int d,
                        input logic r, input int b);
        sv = v;
        sa = AW'(a);
        sd = DW'(d);
        rv = r;
        ra = AW'(b);
        cyc(1);
        sv = 1'b0;
        rv = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        sv = 0; sa = 0; sd = 0; fz = 0; rv = 0; ra = 0;
        #1;
        chk("rst_ren", ren, '0);
        chk("rst_ready", N'(srdy), N'(1));
        chk("rst_pend", N'(pend), '0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // addr 5, delay 3: visible 4 cycles after the handshake
        step(1, 5, 3, 0, 0);
        chk("t1_pend1", N'(pend), N'(1));
        chk("t1_c1", N'(ren[5]), '0);
        cyc(2);
        chk("t1_c3", N'(ren[5]), '0);
        cyc(1);
        chk("t1_c4", N'(ren[5]), N'(1));
        cyc(3);
        chk("t1_hold", N'(ren[5]), N'(1));
        step(0, 0, 0, 1, 5);
        chk("t1_rel", N'(ren[5]), '0);
        chk("t1_pend0", N'(pend), '0);

        // back-to-back addr 2 delay 0, addr 7 delay 2
        step(1, 2, 0, 0, 0);
        chk("t2_b2", N'(ren[2]), N'(1));
        step(1, 7, 2, 0, 0);
        chk("t2_b7_early", N'(ren[7]), '0);
        cyc(2);
        chk("t2_both", ren & N'('h84), N'('h84));
        chk("t2_pend2", N'(pend), N'(2));
        // release 2 while scheduling 10: count unchanged
        step(1, 10, 0, 1, 2);
        chk("t2_pend_same", N'(pend), N'(2));
        step(0, 0, 0, 1, 7);
        step(0, 0, 0, 1, 10);
        chk("t2_pend0", N'(pend), '0);

        // addr 3 delay 4 with 10 frozen cycles
        step(1, 3, 4, 0, 0);
        cyc(1);
        fz = 1'b1;
        cyc(10);
        fz = 1'b0;
        cyc(2);
        chk("t3_early", N'(ren[3]), '0);
        cyc(1);
        chk("t3_due", N'(ren[3]), N'(1));
        step(0, 0, 0, 1, 3);

        // rescheduling a busy slot leaves its countdown alone
        step(1, 9, 5, 0, 0);
        sv = 1'b1; sa = AW'(9); sd = DW'(1);
        #1;
        chk("t4_busy_ready", N'(srdy), '0);
        cyc(3);
        sv = 1'b0;
        cyc(1);
        chk("t4_not_yet", N'(ren[9]), '0);
        cyc(1);
        chk("t4_due", N'(ren[9]), N'(1));
        chk("t4_noerr", N'(err), '0);
        sv = 1'b1; sa = AW'(9); sd = DW'(0); rv = 1'b1; ra = AW'(9);
        cyc(1);
        rv = 1'b0;
        chk("t4_rel_only", N'(ren[9]), '0);
        chk("t4_pend0", N'(pend), '0);
        chk("t4_ready", N'(srdy), N'(1));
        cyc(1);
        sv = 1'b0;
        chk("t4_resched", N'(ren[9]), N'(1));
        chk("t4_pend1", N'(pend), N'(1));
        step(0, 0, 0, 1, 9);

        // stray release sets the sticky error
        step(0, 0, 0, 1, 4);
        chk("t5_err", N'(err), N'(1));
        chk("t5_pend", N'(pend), '0);
        cyc(3);
        chk("t5_sticky", N'(err), N'(1));

        // fill every slot, then reset mid-countdown
        for (int i = 0; i < N; i++) step(1, i, 200, 0, 0);
        chk("t6_full", N'(pend), N'(N));
        cyc(5);
        rst_n = 1'b0;
        #1;
        chk("t6_ren", ren, '0);
        chk("t6_pend", N'(pend), '0);
        chk("t6_err", N'(err), '0);
        chk("t6_ready", N'(srdy), N'(1));
        cyc(2);
        rst_n = 1'b1;
        cyc(300);
        chk("t6_quiet", ren, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/simmem_release_scheduler.md
SIMMEM_RELEASE_SCHEDULER -- requirements
Module: simmem_release_scheduler

Interface
REQ-001 Parameter NumSlots, default 128, number of tracked message-bank slots (power of two, >=2).
REQ-002 Parameter DelayWidth, default 8, width of per-slot delay counter.
REQ-003 Local AddrWidth = $clog2(NumSlots); CntWidth = $clog2(NumSlots)+1.
REQ-004 clk_i  input  1  clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 sched_valid_i  input  1  scheduling request valid.
REQ-007 sched_ready_o  output  1  scheduling request accepted when high with sched_valid_i.
REQ-008 sched_addr_i  input  AddrWidth  message-bank slot address being scheduled.
REQ-009 sched_delay_i  input  DelayWidth  cycles to wait before slot may be released.
REQ-010 freeze_i  input  1  high: all countdowns hold.
REQ-011 release_en_o  output  NumSlots  multi-hot; bit k high = slot k may be released downstream.
REQ-012 released_valid_i  input  1  pulse: downstream bank released a slot this cycle.
REQ-013 released_addr_i  input  AddrWidth  address of released slot.
REQ-014 pending_cnt_o  output  CntWidth  number of scheduled, not yet released slots.
REQ-015 err_o  output  1  sticky protocol-error flag.

Function
REQ-016 Per slot k: state bit busy[k] and counter cnt[k] (DelayWidth bits).
REQ-017 sched_ready_o SHALL equal !busy[sched_addr_i] (registered busy only).
REQ-018 On sched handshake: busy[addr] <= 1, cnt[addr] <= sched_delay_i.
REQ-019 Each cycle with freeze_i low: every busy slot with cnt>0 decrements by 1; cnt SHALL saturate at 0, never wrap.
REQ-020 freeze_i high: no counter changes; scheduling and release handshakes still take effect.
REQ-021 release_en_o[k] SHALL equal busy[k] && cnt[k]==0, purely from registered state.
REQ-022 Delay 0: release_en_o[addr] high the cycle after handshake; delay D, freeze low: high D+1 cycles after handshake.
REQ-023 release_en_o[k] SHALL stay high until released_valid_i with released_addr_i==k; then busy[k] <= 0, release_en_o[k] low next cycle.
REQ-024 Release to slot with release_en_o low (not busy or cnt>0): ignored, err_o <= 1.
REQ-025 Scheduling and release to different slots in same cycle: both take effect.
REQ-026 Release to slot k while sched_addr_i==k same cycle: sched_ready_o is low (slot busy), so only release applies; slot re-schedulable next cycle.
REQ-027 sched_valid_i held high with sched_ready_o low: no state change, no error.
REQ-028 pending_cnt_o = registered count of busy slots; +1 on sched handshake, -1 on valid release, unchanged when both occur; range 0..NumSlots.
REQ-029 err_o once set SHALL remain 1 until reset.
REQ-030 No combinational path from released_* or freeze_i to any output; sched_addr_i->sched_ready_o is the only comb path.

Reset
REQ-031 Asserting rst_ni low SHALL immediately clear busy, cnt, pending_cnt_o, err_o; release_en_o=0; sched_ready_o=1.
REQ-032 Reset mid-countdown discards all scheduled slots; no release_en_o pulse after deassertion.
REQ-033 First handshake accepted on first rising edge with rst_ni high.

Verification
REQ-034 Schedule addr 5, delay 3, freeze low -> release_en_o[5] rises exactly 4 cycles after handshake, holds until release addr 5, pending_cnt_o 1->0.
REQ-035 Schedule addr 2 delay 0 and addr 7 delay 2 back-to-back -> bit 2 high cycle+1, bit 7 high cycle+4; both held concurrently, pending_cnt_o=2.
REQ-036 Schedule addr 3 delay 4, freeze_i high 10 cycles mid-countdown -> release delayed by exactly 10 cycles.
REQ-037 Schedule addr 9 again while busy -> sched_ready_o=0, cnt unchanged; release 9 and schedule 9 same cycle -> release only, reschedule accepted next cycle.
REQ-038 Release addr 4 never scheduled -> err_o=1 next cycle and sticky; pending_cnt_o stays 0.
REQ-039 Fill all NumSlots, assert rst_ni low mid-countdown -> all outputs reset values same cycle, no release_en_o after deassert.
